// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             load, step, last;
   logic             bit_s, carry_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step     = 1'b0;
      last     = 1'b0;
      ready    = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               load     = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == LAST) begin
               last     = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            ready = 1'b1;
            done  = 1'b1;
            if (start) begin
               load     = 1'b1;
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // The single full-adder cell
   assign bit_s    = a_sr[0] ^ b_sr[0] ^ carry;
   assign carry_nx = (a_sr[0] & b_sr[0]) |
                     (a_sr[0] & carry)   |
                     (b_sr[0] & carry);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf    <= 1'b0;
`endif
      end else if (load) begin
         a_sr  <= a;
         // Subtract as a + ~b + 1: the +1 enters through the carry flop
         b_sr  <= sub ? ~b : b;
         carry <= sub;
         cnt   <= '0;
      end else if (step) begin
         a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
         res_sr <= {bit_s, res_sr[WIDTH-1:1]};
         carry  <= carry_nx;
         cnt    <= cnt + CW'(1);
         if (last) begin
            sum  <= {bit_s, res_sr[WIDTH-1:1]};
            cout <= carry_nx;
`ifdef SERIAL_ADDER_OVF_EN
            ovf  <= carry ^ carry_nx;
`endif
         end
      end
   end

endmodule
